// File: rtl/trigger_sequence_controller.sv
// Commanded trigger sequencer: ARM with a delay, count down, fire a bounded
// (or latched) trigger window, and fall back to a safe idle on DISARM or completion.
module trigger_sequence_controller #(
  parameter int CNT_W      = 32,
  parameter int PULSE_CYC  = 16,
  parameter int FIRE_CNT_W = 8
) (
  input  logic                  CLK100MHZ,
  input  logic                  CPU_RESETN,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [CNT_W-1:0]      cmd_delay,
  output logic                  trigger,
  output logic [1:0]            state_o,
  output logic [CNT_W-1:0]      remaining,
  output logic [FIRE_CNT_W-1:0] fire_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_COUNT = 2'b01,
    ST_FIRE  = 2'b10,
    ST_LATCH = 2'b11
  } state_e;

  localparam logic [1:0] OP_ARM    = 2'b01;
  localparam logic [1:0] OP_DISARM = 2'b10;
  localparam logic [1:0] OP_FORCE  = 2'b11;

  localparam int PC_W = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;
  localparam logic [PC_W-1:0] PULSE_LOAD = (PULSE_CYC > 0) ? PC_W'(PULSE_CYC - 1) : '0;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        remaining_q, remaining_d;
  logic [PC_W-1:0]         pulse_q, pulse_d;
  logic [FIRE_CNT_W-1:0]   fire_count_q, fire_count_d, fire_count_inc;
  logic                    trigger_q, trigger_d;
  logic                    accept, is_arm, is_arm_now, is_disarm, is_force, fire_req;

  // A command transfers on any rising edge where cmd_valid && cmd_ready; cmd_ready
  // is tied high so DISARM can never be stalled, and NOP transfers with no effect.
  assign cmd_ready  = 1'b1;
  assign accept     = cmd_valid & cmd_ready;
  assign is_arm     = accept && (cmd_op == OP_ARM) && (cmd_delay != '0);
  assign is_arm_now = accept && (cmd_op == OP_ARM) && (cmd_delay == '0);
  assign is_disarm  = accept && (cmd_op == OP_DISARM);
  assign is_force   = (accept && (cmd_op == OP_FORCE)) || is_arm_now;

  assign fire_count_inc = (&fire_count_q) ? fire_count_q : fire_count_q + FIRE_CNT_W'(1);

  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    pulse_d      = pulse_q;
    fire_count_d = fire_count_q;
    fire_req     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (is_arm) begin
          state_d     = ST_COUNT;
          remaining_d = cmd_delay;
        end else if (is_force) begin
          fire_req = 1'b1;
        end
      end
      ST_COUNT: begin
        // Accepted commands take priority over the countdown expiring on the same edge.
        if (is_disarm) begin
          state_d     = ST_IDLE;
          remaining_d = '0;
        end else if (is_arm) begin
          remaining_d = cmd_delay;
        end else if (is_force || (remaining_q <= CNT_W'(1))) begin
          fire_req = 1'b1;
        end else begin
          remaining_d = remaining_q - CNT_W'(1);
        end
      end
      ST_FIRE: begin
        if (is_disarm) begin
          state_d = ST_IDLE;
          pulse_d = '0;
        end else if (pulse_q == '0) begin
          state_d      = ST_IDLE;
          fire_count_d = fire_count_inc;
        end else begin
          pulse_d = pulse_q - PC_W'(1);
        end
      end
      ST_LATCH: begin
        if (is_disarm) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A zero pulse length means "hold until DISARM", so the fire is counted on entry.
    if (fire_req) begin
      remaining_d = '0;
      if (PULSE_CYC == 0) begin
        state_d      = ST_LATCH;
        fire_count_d = fire_count_inc;
      end else begin
        state_d = ST_FIRE;
        pulse_d = PULSE_LOAD;
      end
    end

    trigger_d = (state_d == ST_FIRE) || (state_d == ST_LATCH);
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_q      <= ST_IDLE;
      remaining_q  <= '0;
      pulse_q      <= '0;
      fire_count_q <= '0;
      trigger_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      pulse_q      <= pulse_d;
      fire_count_q <= fire_count_d;
      trigger_q    <= trigger_d;
    end
  end

  assign trigger    = trigger_q;
  assign state_o    = state_q;
  assign remaining  = remaining_q;
  assign fire_count = fire_count_q;

endmodule
